uart_tx_ctrl: RTL and testbench

- UART transmit controller on the read side of the TX FIFO.
- Pops one word whenever the FIFO is non-empty and the line is idle, then serialises it: start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
- Generates its own bit-period timing from the system clock.
- Sits directly downstream of the FIFO memory/read-pointer logic. Its read-enable drives the FIFO read port, and it consumes the registered read data.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_cnt.sv | 32 +++
 rtl/uart_tx_ctrl.sv | 148 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, default frame/timing parameters
// and parity-mode encodings used by the TX (and later RX) blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CLKS_PER_BIT = 434;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period with o_bit_tick.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_bit_tick
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CLKS_PER_BIT - 1);

  logic [CNT_WIDTH-1:0] r_cnt;

  // Held at zero while disabled so every new bit period starts aligned.
  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST_CNT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_tick = i_en && (r_cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops words from the TX FIFO and serialises them
// as start / data (LSB first) / optional parity / 1-2 stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int               BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);

  tx_state_t             r_state;
  tx_state_t             w_state_next;
  logic                  w_bit_tick;
  logic                  w_baud_en;
  logic                  w_last_stop;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_load_pend;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_two_stop;
  logic                  r_tx;
  logic                  r_rd_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_tx_next;
  logic                  w_rd_en_next;
  logic                  w_busy_next;
  logic                  w_done_next;

  assign w_baud_en = (r_state == ST_START) || (r_state == ST_DATA) ||
                     (r_state == ST_PARITY) || (r_state == ST_STOP);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_baud_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_baud_en),
    .o_bit_tick (w_bit_tick)
  );

  assign w_last_stop = (r_state == ST_STOP) && w_bit_tick &&
                       (!r_two_stop || (r_bit_cnt == BIT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (!fifo_empty) w_state_next = ST_READ;
      ST_READ:   w_state_next = ST_LATCH;
      ST_LATCH:  w_state_next = ST_START;
      ST_START:  if (w_bit_tick) w_state_next = ST_DATA;
      ST_DATA: begin
        if (w_bit_tick && (r_bit_cnt == LAST_DATA)) begin
          w_state_next = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (w_bit_tick) w_state_next = ST_STOP;
      ST_STOP:   if (w_last_stop) w_state_next = fifo_empty ? ST_IDLE : ST_READ;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_next    = 1'b1;
    w_rd_en_next = (r_state == ST_READ);
    w_busy_next  = (r_state != ST_IDLE);
    w_done_next  = w_last_stop;
    case (r_state)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = r_shift[0];
      ST_PARITY: w_tx_next = r_par_bit;
      default:   w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx    <= 1'b1;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tx    <= w_tx_next;
      r_rd_en <= w_rd_en_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  // Read data and line settings arrive one cycle after the read pulse,
  // i.e. during the first START cycle; they stay frozen for the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_pend <= 1'b0;
      r_shift     <= '0;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_two_stop  <= 1'b0;
      r_bit_cnt   <= '0;
    end else begin
      r_load_pend <= (r_state == ST_LATCH);
      if (r_load_pend) begin
        r_shift    <= fifo_rdata;
        r_par_en   <= parity_en;
        r_par_bit  <= (^fifo_rdata) ^ (parity_odd == PARITY_ODD);
        r_two_stop <= two_stop;
      end else if ((r_state == ST_DATA) && w_bit_tick) begin
        r_shift <= r_shift >> 1;
      end
      if (w_state_next != r_state) begin
        r_bit_cnt <= '0;
      end else if (w_bit_tick) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  assign tx         = r_tx;
  assign fifo_rd_en = r_rd_en;
  assign busy       = r_busy;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected frames, a
// monitor captures the serial line per frame and compares against them.
module tb_uart_tx_ctrl;

  localparam int DW  = 8;
  localparam int CPB = 4;

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         par_bit;
    bit         two;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdata = '0;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          two_stop = 1'b0;
  logic          tx;
  logic          busy;
  logic          tx_done;

  logic [7:0] mem [0:15];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  bit         tog_en = 1'b0;
  bit         tog_val = 1'b0;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_pulses = 0;
  int          gap_cnt = 0;
  int          last_gap = -1;
  bit          in_frame = 1'b0;
  int          nsamp = 0;
  logic [63:0] act;

  always #5 clk = ~clk;

  assign fifo_empty = tog_en ? tog_val : (wr_ptr == rd_ptr);

  // FIFO read port model: registered read data one cycle after rd_en.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr % 16];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  uart_tx_ctrl #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  task automatic chk_eq(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  function automatic void build(input exp_t e, output logic [63:0] v, output int len);
    logic [11:0] bits;
    int          nb;
    bits = '1;
    nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < 8; i++) begin
      bits[nb] = e.data[i]; nb++;
    end
    if (e.par_en) begin
      bits[nb] = e.par_bit; nb++;
    end
    bits[nb] = 1'b1; nb++;
    if (e.two) begin
      bits[nb] = 1'b1; nb++;
    end
    v = '1;
    len = nb * CPB;
    for (int i = 0; i < len; i++) v[i] = bits[i / CPB];
  endfunction

  task automatic send(input logic [7:0] d, input bit pe, input bit po, input bit ts,
                      input bit ep, input bit push_exp);
    exp_t e;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    e.data = d; e.par_en = pe; e.par_bit = ep; e.two = ts;
    if (push_exp) exp_q.push_back(e);
    mem[wr_ptr % 16] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tx_low(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    fork
      begin : monitor
        exp_t        e;
        logic [63:0] v;
        int          len;
        forever begin
          @(negedge clk);
          if (rst) begin
            in_frame = 1'b0;
            gap_cnt  = 0;
          end else begin
            if (fifo_rd_en === 1'b1) begin
              rd_pulses++;
              chk_eq("rd_while_nonempty", (wr_ptr != rd_ptr), 1);
            end
            if (!in_frame && tx === 1'b0) begin
              in_frame = 1'b1;
              nsamp    = 0;
              act      = '1;
              last_gap = gap_cnt;
            end
            if (in_frame) begin
              if (nsamp < 64) act[nsamp] = tx;
              nsamp++;
              if (tx_done === 1'b1) begin
                in_frame = 1'b0;
                gap_cnt  = 0;
                if (exp_q.size() == 0) begin
                  chk_eq("frame_unexpected", nsamp, 0);
                end else begin
                  e = exp_q.pop_front();
                  build(e, v, len);
                  $display("frame data=%02h len=%0d line=%0h", e.data, nsamp, act);
                  chk_eq("frame_len", nsamp, len);
                  chk_eq("frame_bits", act, v);
                end
              end else if (nsamp > 64) begin
                in_frame = 1'b0;
                chk_eq("frame_overrun", nsamp, 0);
              end
            end else begin
              gap_cnt++;
              if (tx_done === 1'b1) chk_eq("stray_tx_done", 1, 0);
            end
          end
        end
      end
      begin : stimulus
        bit ok;
        int r0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Idle after reset with an empty FIFO.
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk_eq("idle_tx_busy_rd_done", {tx, busy, fifo_rd_en, tx_done}, 4'b1000);
        end

        // 0xA5, no parity, one stop bit.
        r0 = rd_pulses;
        send(8'hA5, 0, 0, 0, 0, 1);
        wait_done(200, ok);
        chk_eq("a5_done_seen", ok, 1);
        chk_eq("a5_busy_at_done", busy, 1);
        @(negedge clk);
        chk_eq("a5_busy_drop", busy, 0);
        chk_eq("a5_rd_pulses", rd_pulses - r0, 1);

        // 0x07, even parity (bit 1) then odd parity (bit 0).
        repeat (3) @(negedge clk);
        send(8'h07, 1, 0, 0, 1, 1);
        wait_done(200, ok);
        chk_eq("p07_even_done", ok, 1);
        repeat (3) @(negedge clk);
        send(8'h07, 1, 1, 0, 0, 1);
        wait_done(200, ok);
        chk_eq("p07_odd_done", ok, 1);

        // Back-to-back 0x00 / 0xFF with two stop bits.
        repeat (3) @(negedge clk);
        r0 = rd_pulses;
        send(8'h00, 0, 0, 1, 0, 1);
        send(8'hFF, 0, 0, 1, 0, 1);
        wait_done(200, ok);
        chk_eq("b2b_first_done", ok, 1);
        wait_done(200, ok);
        chk_eq("b2b_second_done", ok, 1);
        chk_eq("b2b_rd_pulses", rd_pulses - r0, 2);
        chk_eq("b2b_gap_cycles", last_gap, 2);
        two_stop = 1'b0;

        // Reset during data bit 3 of 0xC3 (bit 3 is 0).
        repeat (5) @(negedge clk);
        r0 = rd_pulses;
        send(8'hC3, 0, 0, 0, 0, 0);
        wait_tx_low(50, ok);
        chk_eq("rst_frame_started", ok, 1);
        repeat (17) @(negedge clk);
        chk_eq("rst_mid_bit3", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("rst_tx_busy", {tx, busy}, 2'b10);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk_eq("post_rst_tx_busy_rd", {tx, busy, fifo_rd_en}, 3'b100);
        end
        chk_eq("rst_rd_pulses", rd_pulses - r0, 1);

        // fifo_empty toggling mid-frame must not cause extra reads.
        r0 = rd_pulses;
        send(8'h5A, 0, 0, 0, 0, 1);
        wait_tx_low(50, ok);
        chk_eq("tog_frame_started", ok, 1);
        tog_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
          tog_val = ~tog_val;
          @(negedge clk);
        end
        tog_en = 1'b0;
        wait_done(100, ok);
        chk_eq("tog_done_seen", ok, 1);
        @(negedge clk);
        chk_eq("tog_busy_drop", busy, 0);
        chk_eq("tog_rd_pulses", rd_pulses - r0, 1);

        repeat (10) @(negedge clk);
        chk_eq("exp_queue_drained", exp_q.size(), 0);
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
